// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write-port arbiter: pipeline priority, buffered long-latency results
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   pipe_valid/pipe_reg/pipe_data     in-order pipeline result; pipe_ready = accepted this cycle
//   lu_valid/lu_reg/lu_data           long-latency result; lu_ready = FIFO not full
//   q1_reg/q2_reg -> q1/q2_pending    live buffered entry targets the queried register
//   reg_write/write_reg/write_data    registered register-file write port
// Optional (macro WB_STATS_EN): stall_cycles (32), kill_count (16) saturating counters.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  q1_reg,
    input  logic [4:0]  q2_reg,
    output logic        q1_pending,
    output logic        q2_pending,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data
`ifdef WB_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] kill_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [4:0]       ent_reg_d  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_live_q, ent_live_d;
    logic [DEPTH-1:0] kill_vec;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;

    logic fifo_empty, force_pop, grant_pipe, pop, push;

    assign fifo_empty = (count_q == '0);
    assign force_pop  = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    assign grant_pipe = pipe_valid && !force_pop;
    assign pop        = !grant_pipe && !fifo_empty;
    // Full is judged before any pop this cycle: no same-cycle pass-through.
    assign lu_ready   = (count_q != CW'(DEPTH));
    assign push       = lu_valid && lu_ready;
    assign pipe_ready = !force_pop;

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    // Live bits are cleared on pop, so a live bit always means an occupied slot.
    always_comb begin
        q1_pending = 1'b0;
        q2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live_q[i] && ent_reg_q[i] == q1_reg) q1_pending = 1'b1;
            if (ent_live_q[i] && ent_reg_q[i] == q2_reg) q2_pending = 1'b1;
        end
        if (q1_reg == 5'd0) q1_pending = 1'b0;
        if (q2_reg == 5'd0) q2_pending = 1'b0;
    end

    always_comb begin
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        kill_vec   = '0;
        // A granted pipeline write is younger than every buffered result to the same register.
        if (grant_pipe && pipe_reg != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_live_q[i] && ent_reg_q[i] == pipe_reg) kill_vec[i] = 1'b1;
            end
        end
        ent_live_d = ent_live_q & ~kill_vec;
        if (pop) ent_live_d[rd_ptr_q] = 1'b0;
        // Applied after the kill so a same-cycle push survives.
        if (push) begin
            ent_reg_d[wr_ptr_q]  = lu_reg;
            ent_data_d[wr_ptr_q] = lu_data;
            ent_live_d[wr_ptr_q] = (lu_reg != 5'd0);
        end
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);

        if (fifo_empty || pop)
            starve_d = '0;
        else if (grant_pipe && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;

        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (grant_pipe) begin
            reg_write_d  = (pipe_reg != 5'd0);
            write_reg_d  = pipe_reg;
            write_data_d = pipe_data;
        end else if (pop) begin
            reg_write_d  = ent_live_q[rd_ptr_q];
            write_reg_d  = ent_reg_q[rd_ptr_q];
            write_data_d = ent_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            ent_live_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            ent_live_q   <= ent_live_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] kill_count_q, kill_count_d;
    logic [16:0] kill_sum;

    always_comb begin
        kill_sum = {1'b0, kill_count_q};
        for (int i = 0; i < DEPTH; i++) kill_sum = kill_sum + 17'(kill_vec[i]);
        kill_count_d   = kill_sum[16] ? 16'hffff : kill_sum[15:0];
        stall_cycles_d = stall_cycles_q;
        if (pipe_valid && !pipe_ready && stall_cycles_q != 32'hffff_ffff)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            kill_count_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            kill_count_q   <= kill_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign kill_count   = kill_count_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid, lu_valid;
    logic [4:0]  pipe_reg, lu_reg, q1_reg, q2_reg;
    logic [31:0] pipe_data, lu_data;
    logic        pipe_ready, lu_ready, q1_pending, q2_pending;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef WB_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] kill_count;
`endif

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
        .q1_reg(q1_reg), .q2_reg(q2_reg), .q1_pending(q1_pending), .q2_pending(q2_pending),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
`ifdef WB_STATS_EN
        , .stall_cycles(stall_cycles), .kill_count(kill_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          pv; logic [4:0] pr; logic [31:0] pd;
        bit          lv; logic [4:0] lr; logic [31:0] ld;
        logic [4:0]  q1;
        bit          rw; logic [4:0] wr; logic [31:0] wd;
        bit          pend; bit prdy; bit lrdy;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] q1, input bit rw, input logic [4:0] wr,
                       input logic [31:0] wd, input bit pend, input bit prdy, input bit lrdy);
        vec_t v;
        v.pv = pv; v.pr = pr; v.pd = pd; v.lv = lv; v.lr = lr; v.ld = ld; v.q1 = q1;
        v.rw = rw; v.wr = wr; v.wd = wd; v.pend = pend; v.prdy = prdy; v.lrdy = lrdy;
        vq.push_back(v);
    endtask

    task automatic drive(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                         input logic [4:0] q1);
        pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
        lu_valid = lv; lu_reg = lr; lu_data = ld; q1_reg = q1; q2_reg = 5'd0;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { logic [4:0] r; logic [31:0] d; bit live; } ent_t;
    ent_t        mq[$];
    int          m_starve;
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    function automatic bit m_force();
        return (mq.size() > 0) && (m_starve == STARVE_LIMIT);
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        mq.delete(); m_starve = 0; m_rw = 0; m_wr = '0; m_wd = '0;
    endtask

    task automatic m_step();
        bit   was_empty, do_push;
        ent_t e;
        was_empty = (mq.size() == 0);
        do_push   = lu_valid && (mq.size() < DEPTH);
        m_rw      = 1'b0;
        if (pipe_valid && !m_force()) begin
            m_rw = (pipe_reg != 5'd0); m_wr = pipe_reg; m_wd = pipe_data;
            if (pipe_reg != 5'd0)
                foreach (mq[i]) if (mq[i].r == pipe_reg) mq[i].live = 1'b0;
            if (was_empty) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end else if (!was_empty) begin
            e = mq.pop_front();
            m_rw = e.live; m_wr = e.r; m_wd = e.d;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        if (do_push) begin
            e.r = lu_reg; e.d = lu_data; e.live = (lu_reg != 5'd0);
            mq.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit exp_prdy, exp_lrdy, hold_pipe;
        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset reg_write", reg_write, 0);
        chk("reset write_reg", write_reg, 0);
        chk("reset write_data", write_data, 0);
        chk("reset lu_ready", lu_ready, 1);
        chk("reset pipe_ready", pipe_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            q1_reg = 5'(r);
            #1;
            chk("idle q1_pending", q1_pending, 0);
        end
        @(posedge clk); #1;
        chk("idle reg_write", reg_write, 0);

        // pipeline only
        add(1, 5, 32'h1234, 0, 0, 0, 5,  1, 5, 32'h1234, 0, 1, 1);
        add(1, 0, 32'hdead, 0, 0, 0, 5,  0, 0, 0,        0, 1, 1);
        add(0, 0, 0,        0, 0, 0, 5,  0, 0, 0,        0, 1, 1);
        // priority and starvation-forced pop
        add(1, 1, 32'h100,  1, 8, 32'haa, 8,  1, 1, 32'h100, 1, 1, 1);
        for (int i = 0; i < STARVE_LIMIT; i++)
            add(1, 2, 32'h200 + i, 0, 0, 0, 8, 1, 2, 32'h200 + i, 1,
                (i == STARVE_LIMIT - 1) ? 1'b0 : 1'b1, 1);
        add(1, 2, 32'h300, 0, 0, 0, 8,  1, 8, 32'haa,  0, 1, 1);
        add(1, 2, 32'h300, 0, 0, 0, 8,  1, 2, 32'h300, 0, 1, 1);
        // WAW kill
        add(0, 0, 0,       1, 3, 32'h11, 3,  0, 0, 0,       1, 1, 1);
        add(1, 3, 32'h22,  0, 0, 0,      3,  1, 3, 32'h22,  0, 1, 1);
        add(0, 0, 0,       0, 0, 0,      3,  0, 0, 0,       0, 1, 1);
        add(0, 0, 0,       0, 0, 0,      3,  0, 0, 0,       0, 1, 1);
        // full FIFO, then drain in order
        for (int i = 0; i < DEPTH; i++)
            add(1, 4, 32'h40 + i, 1, 5'(10 + i), 32'h500 + i, 12, 1, 4, 32'h40 + i,
                (i >= 2) ? 1'b1 : 1'b0, 1, (i == DEPTH - 1) ? 1'b0 : 1'b1);
        add(0, 0, 0, 1, 20, 32'hbad, 20,  1, 10, 32'h500, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,       12,  1, 11, 32'h501, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,       12,  1, 12, 32'h502, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,       12,  1, 13, 32'h503, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,       20,  0, 0,  0,       0, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].pv, vq[i].pr, vq[i].pd, vq[i].lv, vq[i].lr, vq[i].ld, vq[i].q1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d reg_write", i), reg_write, vq[i].rw);
            if (vq[i].rw) begin
                chk($sformatf("vec%0d write_reg", i), write_reg, vq[i].wr);
                chk($sformatf("vec%0d write_data", i), write_data, vq[i].wd);
            end
            chk($sformatf("vec%0d q1_pending", i), q1_pending, vq[i].pend);
            chk($sformatf("vec%0d pipe_ready", i), pipe_ready, vq[i].prdy);
            chk($sformatf("vec%0d lu_ready", i), lu_ready, vq[i].lrdy);
        end

        // async reset with three buffered entries
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 1, (i == 0) ? 5'd6 : (i == 1) ? 5'd7 : 5'd9, 32'h600 + i, 6);
        end
        @(negedge clk);
        drive(1, 1, 32'habc, 0, 0, 0, 6);
        @(posedge clk); #1;
        chk("pre-reset reg_write", reg_write, 1);
        chk("pre-reset q1_pending", q1_pending, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset reg_write", reg_write, 0);
        chk("async reset write_reg", write_reg, 0);
        chk("async reset write_data", write_data, 0);
        chk("async reset q1_pending", q1_pending, 0);
        chk("async reset lu_ready", lu_ready, 1);
        chk("async reset pipe_ready", pipe_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 7);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post-reset reg_write", reg_write, 0);
            chk("post-reset q1_pending", q1_pending, 0);
        end

        // randomized run against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        hold_pipe = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!hold_pipe) begin
                pipe_valid = ($urandom_range(0, 9) < 7);
                pipe_reg   = 5'($urandom_range(0, 7));
                pipe_data  = $urandom;
            end
            lu_valid = ($urandom_range(0, 2) == 0);
            lu_reg   = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            q1_reg   = 5'($urandom_range(0, 7));
            q2_reg   = 5'($urandom_range(0, 31));
            #1;
            exp_prdy = !m_force();
            exp_lrdy = (mq.size() < DEPTH);
            chk("rand pipe_ready", pipe_ready, exp_prdy);
            chk("rand lu_ready", lu_ready, exp_lrdy);
            chk("rand q1_pending", q1_pending, m_pending(q1_reg));
            chk("rand q2_pending", q2_pending, m_pending(q2_reg));
            hold_pipe = pipe_valid && !exp_prdy;
            m_step();
            @(posedge clk); #1;
            chk("rand reg_write", reg_write, m_rw);
            if (m_rw) begin
                chk("rand write_reg", write_reg, m_wr);
                chk("rand write_data", write_data, m_wd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
